// File: rtl/mul_ctrl_pkg.sv
// Shared types and constants for the 16x16 sequential multiply controller.
// Optional signed-operand mode is selected with MUL16_SIGNED_EN in the top module.
package mul_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [1:0] step_t;

    localparam step_t STEP_LAST = 2'd3;
    localparam int    SHIFT_0   = 0;
    localparam int    SHIFT_1   = 8;
    localparam int    SHIFT_2   = 8;
    localparam int    SHIFT_3   = 16;

    // Left shift applied to the 8x8 partial product of each step.
    function automatic logic [4:0] step_shift(input step_t s);
        logic [4:0] sh;
        case (s)
            2'd0:    sh = 5'(SHIFT_0);
            2'd1:    sh = 5'(SHIFT_1);
            2'd2:    sh = 5'(SHIFT_2);
            default: sh = 5'(SHIFT_3);
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/mul16_seq_ctrl_if.sv
// Request/response bundle of the sequential multiplier.
// Handshake: a beat transfers on a rising clk edge where valid && ready; valid side holds its data until then.
interface mul16_seq_ctrl_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_p;
    logic        busy;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p, busy
    );

endinterface

// File: rtl/mul16_seq_ctrl_vedic8.sv
// Existing 8x8 unsigned Vedic (vertically-and-crosswise) multiplier, combinational.
// Built recursively from 2x2 blocks: each level sums four half-width crosswise products.
module vedic_mul8 (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o
);

    function automatic logic [3:0] v2(input logic [1:0] a, input logic [1:0] b);
        return {3'b000, a[0] & b[0]}
             + {2'b00, a[1] & b[0], 1'b0}
             + {2'b00, a[0] & b[1], 1'b0}
             + {1'b0,  a[1] & b[1], 2'b00};
    endfunction

    function automatic logic [7:0] v4(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] ll, lh, hl, hh;
        ll = v2(a[1:0], b[1:0]);
        lh = v2(a[1:0], b[3:2]);
        hl = v2(a[3:2], b[1:0]);
        hh = v2(a[3:2], b[3:2]);
        return {4'b0000, ll} + {2'b00, lh, 2'b00} + {2'b00, hl, 2'b00} + {hh, 4'b0000};
    endfunction

    logic [7:0] ll, lh, hl, hh;

    always_comb begin
        ll  = v4(a_i[3:0], b_i[3:0]);
        lh  = v4(a_i[3:0], b_i[7:4]);
        hl  = v4(a_i[7:4], b_i[3:0]);
        hh  = v4(a_i[7:4], b_i[7:4]);
        p_o = {8'h00, ll} + {4'h0, lh, 4'h0} + {4'h0, hl, 4'h0} + {hh, 8'h00};
    end

endmodule

// File: rtl/mul16_seq_ctrl.sv
// 16x16 -> 32 multiply sequenced over four byte-pair steps through one vedic_mul8.
// Define MUL16_SIGNED_EN for two's-complement operands (magnitude multiply + sign fix-up).
module mul16_seq_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int unsigned PP_REG = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    mul16_seq_ctrl_if.slave       bus,
    output state_t                state_o
);

    state_t      state_q, state_d;
    step_t       step_q,  step_d;
    logic        phase_q, phase_d;
    logic [15:0] a_q,     a_d;
    logic [15:0] b_q,     b_d;
    logic [31:0] acc_q,   acc_d;
    logic [31:0] p_q,     p_d;
    logic [15:0] pp_q,    pp_d;
`ifdef MUL16_SIGNED_EN
    logic        sign_q,  sign_d;
`endif

    logic [7:0]  a_byte;
    logic [7:0]  b_byte;
    logic [15:0] pp_comb;
    logic [15:0] pp_use;
    logic [31:0] acc_next;
    logic        pp_reg_en;

    // Step bit 1 picks the high byte of a, step bit 0 the high byte of b.
    assign a_byte = step_q[1] ? a_q[15:8] : a_q[7:0];
    assign b_byte = step_q[0] ? b_q[15:8] : b_q[7:0];

    vedic_mul8 u_mul8 (
        .a_i (a_byte),
        .b_i (b_byte),
        .p_o (pp_comb)
    );

    assign pp_reg_en = (PP_REG != 0);
    assign pp_use    = pp_reg_en ? pp_q : pp_comb;
    assign acc_next  = acc_q + ({16'h0000, pp_use} << step_shift(step_q));

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        phase_d = phase_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        p_d     = p_q;
        pp_d    = pp_q;
`ifdef MUL16_SIGNED_EN
        sign_d  = sign_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
`ifdef MUL16_SIGNED_EN
                    a_d    = bus.in_a[15] ? (~bus.in_a + 16'd1) : bus.in_a;
                    b_d    = bus.in_b[15] ? (~bus.in_b + 16'd1) : bus.in_b;
                    sign_d = bus.in_a[15] ^ bus.in_b[15];
`else
                    a_d    = bus.in_a;
                    b_d    = bus.in_b;
`endif
                    acc_d   = 32'h0;
                    step_d  = 2'd0;
                    phase_d = 1'b0;
                    state_d = MUL;
                end
            end
            MUL: begin
                if (pp_reg_en && !phase_q) begin
                    pp_d    = pp_comb;
                    phase_d = 1'b1;
                end else begin
                    acc_d   = acc_next;
                    phase_d = 1'b0;
                    if (step_q == STEP_LAST) begin
                        state_d = DONE;
`ifdef MUL16_SIGNED_EN
                        p_d = sign_q ? (~acc_next + 32'd1) : acc_next;
`else
                        p_d = acc_next;
`endif
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= 2'd0;
            phase_q <= 1'b0;
            a_q     <= 16'h0;
            b_q     <= 16'h0;
            acc_q   <= 32'h0;
            p_q     <= 32'h0;
            pp_q    <= 16'h0;
`ifdef MUL16_SIGNED_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            phase_q <= phase_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            pp_q    <= pp_d;
`ifdef MUL16_SIGNED_EN
            sign_q  <= sign_d;
`endif
        end
    end

    // in_ready is masked by rst so nothing is offered while reset is held.
    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_p     = p_q;
    assign bus.busy      = (state_q != IDLE);
    assign state_o       = state_q;

endmodule
